// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: h/v counters, registered hsync/vsync/de and image-window coordinates.
// Build option VGA_TIMING_ROM_ALIGN_EN delays hsync/vsync/de by one pixel tick to line up with the image ROM.
module vga_timing_gen #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic SYNC_POL = 1'b0,
    parameter int   IMG_X0   = 270,
    parameter int   IMG_Y0   = 190,
    parameter int   IMG_W    = 100,
    parameter int   IMG_H    = 100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pix_ce,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic        img_valid,
    output logic [15:0] x,
    output logic [15:0] y,
    output logic        frame_start
);
    localparam logic [15:0] H_LAST = 16'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [15:0] V_LAST = 16'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [15:0] H_ACT  = 16'(H_ACTIVE);
    localparam logic [15:0] V_ACT  = 16'(V_ACTIVE);
    localparam logic [15:0] HS_BEG = 16'(H_ACTIVE + H_FP);
    localparam logic [15:0] HS_END = 16'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [15:0] VS_BEG = 16'(V_ACTIVE + V_FP);
    localparam logic [15:0] VS_END = 16'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [15:0] X_BEG  = 16'(IMG_X0);
    localparam logic [15:0] X_END  = 16'(IMG_X0 + IMG_W);
    localparam logic [15:0] Y_BEG  = 16'(IMG_Y0);
    localparam logic [15:0] Y_END  = 16'(IMG_Y0 + IMG_H);

    logic [15:0] h_cnt, v_cnt, h_nxt, v_nxt, x_nxt, y_nxt;
    logic        wrap, de_nxt, img_nxt, hs_nxt, vs_nxt;
    logic        hs_q, vs_q, de_q;

    // Decode from the next counter values so registered outputs describe the counters they land with.
    always_comb begin
        h_nxt = h_cnt + 16'd1;
        v_nxt = v_cnt;
        wrap  = 1'b0;
        if (h_cnt == H_LAST) begin
            h_nxt = '0;
            if (v_cnt == V_LAST) begin
                v_nxt = '0;
                wrap  = 1'b1;
            end else begin
                v_nxt = v_cnt + 16'd1;
            end
        end
        de_nxt  = (h_nxt < H_ACT) && (v_nxt < V_ACT);
        img_nxt = de_nxt && (h_nxt >= X_BEG) && (h_nxt < X_END)
                         && (v_nxt >= Y_BEG) && (v_nxt < Y_END);
        hs_nxt  = ((h_nxt >= HS_BEG) && (h_nxt < HS_END)) ? SYNC_POL : ~SYNC_POL;
        vs_nxt  = ((v_nxt >= VS_BEG) && (v_nxt < VS_END)) ? SYNC_POL : ~SYNC_POL;
        x_nxt   = img_nxt ? (h_nxt - X_BEG) : '0;
        y_nxt   = img_nxt ? (v_nxt - Y_BEG) : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt       <= '0;
            v_cnt       <= '0;
            hs_q        <= ~SYNC_POL;
            vs_q        <= ~SYNC_POL;
            de_q        <= 1'b0;
            img_valid   <= 1'b0;
            x           <= '0;
            y           <= '0;
            frame_start <= 1'b0;
        end else if (pix_ce) begin
            h_cnt       <= h_nxt;
            v_cnt       <= v_nxt;
            hs_q        <= hs_nxt;
            vs_q        <= vs_nxt;
            de_q        <= de_nxt;
            img_valid   <= img_nxt;
            x           <= x_nxt;
            y           <= y_nxt;
            frame_start <= wrap;
        end else begin
            frame_start <= 1'b0;
        end
    end

`ifdef VGA_TIMING_ROM_ALIGN_EN
    // Extra pixel stage so sync/de meet ROM data that arrives one tick after x/y.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hsync <= ~SYNC_POL;
            vsync <= ~SYNC_POL;
            de    <= 1'b0;
        end else if (pix_ce) begin
            hsync <= hs_q;
            vsync <= vs_q;
            de    <= de_q;
        end
    end
`else
    assign hsync = hs_q;
    assign vsync = vs_q;
    assign de    = de_q;
`endif

endmodule
